// File: rtl/ret_addr_pusher.sv
// Pushes the return context (flags for interrupts, then PC low and high words)
// onto the data-memory stack, holding fetch until the stack image is complete.
module ret_addr_pusher (
   input  logic        clk,
   input  logic        reset,
   input  logic        call_req,
   input  logic        int_req,
   input  logic [31:0] ret_pc,
   input  logic [2:0]  flags,
   input  logic [31:0] sp,
   input  logic        mem_grant,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        sp_wr_en,
   output logic [31:0] sp_next,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PUSH_FLAGS = 3'd1,
      PUSH_LO    = 3'd2,
      PUSH_HI    = 3'd3,
      DONE       = 3'd4
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [2:0]  fl_q;
   logic        push_s;
   logic [15:0] word_s;

   // State register; shares the falling-edge domain with the PC register
   always_ff @(negedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Context capture on acceptance, then one modular decrement per granted write
   always_ff @(negedge clk) begin
      if (reset) begin
         pc_q   <= 32'd0;
         fl_q   <= 3'd0;
         addr_q <= 32'd0;
      end else if ((state_r == IDLE) && (int_req || call_req)) begin
         pc_q   <= ret_pc;
         fl_q   <= flags;
         addr_q <= sp;
      end else if (push_s && mem_grant) begin
         addr_q <= addr_q - 32'd1;
      end
   end

   // Next-state logic; interrupt beats a simultaneous CALL
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (int_req) begin
               next_state_s = PUSH_FLAGS;
            end else if (call_req) begin
               next_state_s = PUSH_LO;
            end else begin
               next_state_s = IDLE;
            end
         end
         PUSH_FLAGS: next_state_s = mem_grant ? PUSH_LO : PUSH_FLAGS;
         PUSH_LO:    next_state_s = mem_grant ? PUSH_HI : PUSH_LO;
         PUSH_HI:    next_state_s = mem_grant ? DONE    : PUSH_HI;
         DONE:       next_state_s = IDLE;
         default:    next_state_s = IDLE;
      endcase
   end

   // Word selection for the current push state
   always_comb begin
      push_s = 1'b0;
      word_s = 16'd0;
      case (state_r)
         PUSH_FLAGS: begin
            push_s = 1'b1;
            word_s = {13'd0, fl_q};
         end
         PUSH_LO: begin
            push_s = 1'b1;
            word_s = pc_q[15:0];
         end
         PUSH_HI: begin
            push_s = 1'b1;
            word_s = pc_q[31:16];
         end
         default: begin
            push_s = 1'b0;
            word_s = 16'd0;
         end
      endcase
   end

   // Outputs; data buses stay zero whenever their strobe is low
   always_comb begin
      mem_wr_en = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 16'd0;
      sp_wr_en  = 1'b0;
      sp_next   = 32'd0;
      busy      = (state_r != IDLE);
      done      = (state_r == DONE);
      if (push_s && mem_grant) begin
         mem_wr_en = 1'b1;
         mem_addr  = addr_q;
         mem_wdata = word_s;
         sp_wr_en  = 1'b1;
         sp_next   = addr_q - 32'd1;
      end else begin
         mem_wr_en = 1'b0;
         sp_wr_en  = 1'b0;
      end
   end

endmodule

// File: tb/tb_ret_addr_pusher.sv
// Table-driven bench for ret_addr_pusher with a write scoreboard; the DUT
// updates on the falling edge, inputs change just after it, outputs are read on the rising edge.
module tb_ret_addr_pusher;

   logic        clk = 1'b0;
   logic        reset, call_req, int_req, mem_grant;
   logic [31:0] ret_pc, sp;
   logic [2:0]  flags;
   logic        mem_wr_en, sp_wr_en, busy, done;
   logic [31:0] mem_addr, sp_next;
   logic [15:0] mem_wdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        call;
      logic        intr;
      logic [31:0] sp;
      logic [31:0] pc;
      logic [2:0]  fl;
      logic [7:0]  stall;
      int          recall;
      int          done_at;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      logic [31:0] spn;
   } wr_t;

   vec_t tbl[6];
   wr_t  q[$];
   wr_t  w;

   ret_addr_pusher dut (
      .clk(clk), .reset(reset), .call_req(call_req), .int_req(int_req),
      .ret_pc(ret_pc), .flags(flags), .sp(sp), .mem_grant(mem_grant),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .sp_wr_en(sp_wr_en), .sp_next(sp_next), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic cr, input logic ir, input logic g, input logic rs,
                      input logic [31:0] pc, input logic [31:0] spv, input logic [2:0] fl);
      @(negedge clk);
      #1;
      call_req  = cr;
      int_req   = ir;
      mem_grant = g;
      reset     = rs;
      ret_pc    = pc;
      sp        = spv;
      flags     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wr"},    {31'd0, mem_wr_en}, 32'd0);
      chk({tag, "_spwr"},  {31'd0, sp_wr_en},  32'd0);
      chk({tag, "_addr"},  mem_addr,           32'd0);
      chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
      chk({tag, "_spn"},   sp_next,            32'd0);
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.spn  = a - 32'd1;
      q.push_back(e);
   endtask

   initial begin
      logic [31:0] a;

      tbl[0] = '{call:1'b1, intr:1'b0, sp:32'h0000_03FF, pc:32'h0001_0020, fl:3'b000,
                 stall:8'h00, recall:-1, done_at:3};
      tbl[1] = '{call:1'b0, intr:1'b1, sp:32'h0000_03FF, pc:32'h0000_0041, fl:3'b101,
                 stall:8'h00, recall:-1, done_at:4};
      tbl[2] = '{call:1'b1, intr:1'b0, sp:32'h0000_03FF, pc:32'h0001_0020, fl:3'b000,
                 stall:8'h06, recall:-1, done_at:5};
      tbl[3] = '{call:1'b1, intr:1'b1, sp:32'h0000_1000, pc:32'hDEAD_BEEF, fl:3'b011,
                 stall:8'h00, recall:2, done_at:4};
      tbl[4] = '{call:1'b1, intr:1'b0, sp:32'h0000_0000, pc:32'h1234_5678, fl:3'b000,
                 stall:8'h00, recall:-1, done_at:3};
      tbl[5] = '{call:1'b0, intr:1'b1, sp:32'h8000_0001, pc:32'hCAFE_F00D, fl:3'b110,
                 stall:8'h04, recall:-1, done_at:5};

      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 3'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 3'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk_quiet("rst");

      for (int v = 0; v < 6; v++) begin
         a = tbl[v].sp;
         if (tbl[v].intr) begin
            push_exp(a, {13'd0, tbl[v].fl});
            a = a - 32'd1;
         end
         push_exp(a, tbl[v].pc[15:0]);
         push_exp(a - 32'd1, tbl[v].pc[31:16]);

         // request cycle doubles as the idle cycle following the previous DONE
         cyc(tbl[v].call, tbl[v].intr, 1'b1, 1'b0, tbl[v].pc, tbl[v].sp, tbl[v].fl);
         chk("idle_busy", {31'd0, busy}, 32'd0);
         chk("idle_done", {31'd0, done}, 32'd0);
         chk_quiet("idle");

         for (int k = 1; k <= tbl[v].done_at; k++) begin
            cyc(k == tbl[v].recall, 1'b0, ~tbl[v].stall[k], 1'b0,
                $urandom, $urandom, 3'($urandom_range(7, 0)));
            if (mem_wr_en) begin
               if (q.size() == 0) begin
                  chk("extra_write", mem_addr, 32'hFFFF_FFFF ^ mem_addr);
               end else begin
                  w = q.pop_front();
                  chk("wr_addr",  mem_addr,           w.addr);
                  chk("wr_data",  {16'd0, mem_wdata}, {16'd0, w.data});
                  chk("wr_spn",   sp_next,            w.spn);
                  chk("wr_spwr",  {31'd0, sp_wr_en},  32'd1);
               end
            end else begin
               chk_quiet("nowr");
            end
            chk("busy", {31'd0, busy}, 32'd1);
            chk("done", {31'd0, done}, {31'd0, (k == tbl[v].done_at)});
         end
         chk("q_empty", q.size(), 32'd0);
         q.delete();
      end

      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk_quiet("end");

      // reset while in PUSH_HI with the port withheld
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hABCD_1234, 32'h0000_0200, 3'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("rh_lo_wr",   {31'd0, mem_wr_en}, 32'd1);
      chk("rh_lo_addr", mem_addr,           32'h0000_0200);
      chk("rh_lo_data", {16'd0, mem_wdata}, 32'h0000_1234);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 3'd0);
      chk("rh_hi_busy", {31'd0, busy}, 32'd1);
      chk_quiet("rh_hi");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("rh_busy", {31'd0, busy}, 32'd0);
      chk("rh_done", {31'd0, done}, 32'd0);
      chk_quiet("rh_after");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
      chk("rh_done2", {31'd0, done}, 32'd0);
      chk_quiet("rh_after2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
